// File: rtl/arm_seq_alu.sv
// Multi-cycle ALU with NZCV flag register: single-cycle ADD/SUB/AND/ORR/EOR/BIC,
// iterative shift-add MUL, start/done handshake towards the register-file write port.
module arm_seq_alu #(
  parameter int          WIDTH      = 32,
  parameter bit          MUL_EN     = 1'b1,
  parameter logic [3:0]  FLAG_RESET = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic             no_write,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_we,
  output logic             err,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_q, s_d, nw_q, nw_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d, we_q, we_d;

  logic             is_sub, alu_arith, alu_legal, op_mul, alu_v;
  logic [WIDTH-1:0] b_op, alu_res, acc_step;
  logic [WIDTH:0]   sum;

  function automatic logic [1:0] nz_of(input logic [WIDTH-1:0] r);
    nz_of = {r[WIDTH-1], (r == {WIDTH{1'b0}})};
  endfunction

  // Single-cycle datapath and opcode decode; SUB is a + ~b + 1 so C means no borrow
  always_comb begin
    is_sub    = (op == 4'b0001);
    b_op      = is_sub ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    alu_v     = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ is_sub) & (a[WIDTH-1] ^ sum[WIDTH-1]);
    alu_arith = 1'b0;
    alu_legal = 1'b1;
    op_mul    = 1'b0;
    alu_res   = {WIDTH{1'b0}};
    case (op)
      4'b0000, 4'b0001: begin
        alu_res   = sum[WIDTH-1:0];
        alu_arith = 1'b1;
      end
      4'b0010: alu_res = a & b;
      4'b0011: alu_res = a | b;
      4'b0100: alu_res = a ^ b;
      4'b0101: alu_res = a & ~b;
      4'b1000: begin
        op_mul    = MUL_EN;
        alu_legal = MUL_EN;
      end
      default: alu_legal = 1'b0;
    endcase
  end

  // One shift-add multiplier step
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    nw_d     = nw_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = 1'b0;
    we_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d  = s;
          nw_d = no_write;
          if (!alu_legal) begin
            state_d  = ST_DONE;
            result_d = {WIDTH{1'b0}};
            err_d    = 1'b1;
          end else if (op_mul) begin
            state_d  = ST_MUL;
            acc_d    = {WIDTH{1'b0}};
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = {CW{1'b0}};
          end else begin
            state_d  = ST_DONE;
            result_d = alu_res;
            we_d     = ~no_write;
            if (s) begin
              flags_d = {nz_of(alu_res),
                         alu_arith ? sum[WIDTH] : flags_q[1],
                         alu_arith ? alu_v      : flags_q[0]};
            end else begin
              flags_d = flags_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = ST_DONE;
          result_d = acc_step;
          we_d     = ~nw_q;
          if (s_q) begin
            flags_d = {nz_of(acc_step), flags_q[1:0]};
          end else begin
            flags_d = flags_q;
          end
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset aborts any multiply in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      s_q      <= 1'b0;
      nw_q     <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      flags_q  <= FLAG_RESET;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      nw_q     <= nw_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      we_q     <= we_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_we = we_q;
  assign err       = err_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_arm_seq_alu.sv
// Randomised self-checking bench for arm_seq_alu against an arithmetic reference model.
module tb_arm_seq_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        s = 1'b0, no_write = 1'b0;
  logic        busy, done, result_we, err;
  logic [31:0] result;
  logic [3:0]  flags;

  logic [7:0]  a8, b8;
  logic        busy0, done0, we0, err0;
  logic [7:0]  result0;
  logic [3:0]  flags0;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_flags;

  always #5 clk = ~clk;

  assign a8 = a[7:0];
  assign b8 = b[7:0];

  arm_seq_alu #(.WIDTH(32), .MUL_EN(1'b1), .FLAG_RESET(4'b0000)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .s(s),
    .no_write(no_write), .busy(busy), .done(done), .result(result),
    .result_we(result_we), .err(err), .flags(flags)
  );

  arm_seq_alu #(.WIDTH(8), .MUL_EN(1'b0), .FLAG_RESET(4'b0000)) u_dut_nomul (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a8), .b(b8), .s(s),
    .no_write(no_write), .busy(busy0), .done(done0), .result(result0),
    .result_we(we0), .err(err0), .flags(flags0)
  );

  // Reference: ARM-style result and NZCV from plain integer arithmetic
  task automatic ref_model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic sb, input logic [3:0] f_in,
                           output logic [31:0] r, output logic [3:0] f_out, output logic e);
    logic [63:0] wide;
    longint      sr;
    logic        c, v;
    e = 1'b0; c = f_in[1]; v = f_in[0]; r = 32'd0;
    case (o)
      4'd0: begin
        wide = {32'd0, x} + {32'd0, y};
        r = wide[31:0]; c = wide[32];
        sr = longint'($signed(x)) + longint'($signed(y));
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd1: begin
        r = x - y; c = (x >= y);
        sr = longint'($signed(x)) - longint'($signed(y));
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = x & ~y;
      4'd8: r = x * y;
      default: e = 1'b1;
    endcase
    if (sb && !e) f_out = {r[31], (r == 32'd0), c, v};
    else          f_out = f_in;
  endtask

  // Issue one op and wait (bounded) for done; lat=0 means no done seen
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic sb, input logic nwb, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; s = sb; no_write = nwb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; s = $urandom_range(0, 1); no_write = $urandom_range(0, 1);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0)         begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (result_we !== 1'b0)   begin errors++; $display("FAIL reset_we got %b want 0", result_we); end
    checks++; if (result !== 32'd0)     begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (flags !== 4'b0000)    begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
    reset = 1'b1;
    exp_flags = 4'b0000;
  endtask

  task automatic test_directed;
    int lat;
    run_op(4'd0, 32'h7FFFFFFF, 32'd1, 1'b1, 1'b0, lat);
    checks++; if (lat !== 1)              begin errors++; $display("FAIL add_ovf_lat got %0d want 1", lat); end
    checks++; if (result !== 32'h80000000) begin errors++; $display("FAIL add_ovf_result got %h want 80000000", result); end
    checks++; if (result_we !== 1'b1)     begin errors++; $display("FAIL add_ovf_we got %b want 1", result_we); end
    checks++; if (flags !== 4'b1001)      begin errors++; $display("FAIL add_ovf_flags got %b want 1001", flags); end
    run_op(4'd1, 32'd5, 32'd5, 1'b1, 1'b1, lat);
    checks++; if (result !== 32'd0)       begin errors++; $display("FAIL cmp_result got %h want 0", result); end
    checks++; if (result_we !== 1'b0)     begin errors++; $display("FAIL cmp_we got %b want 0", result_we); end
    checks++; if (flags !== 4'b0110)      begin errors++; $display("FAIL cmp_flags got %b want 0110", flags); end
    run_op(4'd8, 32'd7, 32'd6, 1'b1, 1'b0, lat);
    checks++; if (lat !== 33)             begin errors++; $display("FAIL mul_lat got %0d want 33", lat); end
    checks++; if (result !== 32'd42)      begin errors++; $display("FAIL mul_result got %0d want 42", result); end
    checks++; if (flags !== 4'b0010)      begin errors++; $display("FAIL mul_flags got %b want 0010", flags); end
    checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL mul_busy_in_done got %b want 1", busy); end
    exp_flags = 4'b0010;
  endtask

  task automatic test_random;
    int lat, pick;
    logic [3:0]  o;
    logic [31:0] x, y, r;
    logic [3:0]  f;
    logic        sb, nwb, e;
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 7);
      case (pick)
        6:       o = 4'd8;
        7:       o = 4'($urandom_range(9, 15));
        default: o = 4'(pick);
      endcase
      x = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      sb = $urandom_range(0, 1); nwb = $urandom_range(0, 1);
      ref_model(o, x, y, sb, exp_flags, r, f, e);
      run_op(o, x, y, sb, nwb, lat);
      checks++; if (lat !== ((o == 4'd8) ? 33 : 1)) begin errors++; $display("FAIL rnd_lat op=%h got %0d", o, lat); end
      checks++; if (result !== r)   begin errors++; $display("FAIL rnd_result op=%h a=%h b=%h got %h want %h", o, x, y, result, r); end
      checks++; if (flags !== f)    begin errors++; $display("FAIL rnd_flags op=%h a=%h b=%h got %b want %b", o, x, y, flags, f); end
      checks++; if (err !== e)      begin errors++; $display("FAIL rnd_err op=%h got %b want %b", o, err, e); end
      checks++; if (result_we !== (!nwb && !e)) begin errors++; $display("FAIL rnd_we op=%h got %b want %b", o, result_we, !nwb && !e); end
      exp_flags = f;
    end
  endtask

  task automatic test_ignore_start;
    int ndone, lat;
    @(negedge clk);
    op = 4'd8; a = 32'd9; b = 32'd11; s = 1'b0; no_write = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; lat = 0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 5) begin op = 4'd0; a = 32'd1; b = 32'd1; start = 1'b1; end
      if (n == 6) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        lat = n;
        checks++; if (result !== 32'd99) begin errors++; $display("FAIL ign_result got %0d want 99", result); end
      end
      @(negedge clk);
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", ndone); end
    checks++; if (lat !== 33)  begin errors++; $display("FAIL ign_lat got %0d want 33", lat); end
    checks++; if (flags !== exp_flags) begin errors++; $display("FAIL ign_flags got %b want %b", flags, exp_flags); end
  endtask

  task automatic test_reset_mid_mul;
    int lat, ndone;
    run_op(4'd0, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, lat);
    exp_flags = 4'b1000;
    @(negedge clk);
    op = 4'd8; a = 32'd123; b = 32'd456; s = 1'b1; no_write = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmul_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rstmul_done got %b want 0", done); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rstmul_flags got %b want 0000", flags); end
    @(negedge clk);
    reset = 1'b1;
    exp_flags = 4'b0000;
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rstmul_stray_done got %0d want 0", ndone); end
    run_op(4'd0, 32'd2, 32'd3, 1'b1, 1'b0, lat);
    checks++; if (result !== 32'd5)  begin errors++; $display("FAIL rstmul_add_result got %0d want 5", result); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rstmul_add_flags got %b want 0000", flags); end
  endtask

  task automatic test_illegal;
    int lat;
    run_op(4'd1, 32'd1, 32'd2, 1'b1, 1'b0, lat);
    exp_flags = 4'b1000;
    run_op(4'b1111, 32'd10, 32'd20, 1'b1, 1'b0, lat);
    checks++; if (lat !== 1)           begin errors++; $display("FAIL ill_lat got %0d want 1", lat); end
    checks++; if (err !== 1'b1)        begin errors++; $display("FAIL ill_err got %b want 1", err); end
    checks++; if (result !== 32'd0)    begin errors++; $display("FAIL ill_result got %h want 0", result); end
    checks++; if (result_we !== 1'b0)  begin errors++; $display("FAIL ill_we got %b want 0", result_we); end
    checks++; if (flags !== exp_flags) begin errors++; $display("FAIL ill_flags got %b want %b", flags, exp_flags); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_flags = 4'b0000;
    op = 4'd8; a = 32'd3; b = 32'd5; s = 1'b1; no_write = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++; if (done0 !== 1'b1)      begin errors++; $display("FAIL nomul_done got %b want 1", done0); end
    checks++; if (err0 !== 1'b1)       begin errors++; $display("FAIL nomul_err got %b want 1", err0); end
    checks++; if (busy0 !== 1'b1)      begin errors++; $display("FAIL nomul_busy got %b want 1", busy0); end
    checks++; if (result0 !== 8'd0)    begin errors++; $display("FAIL nomul_result got %h want 0", result0); end
    checks++; if (we0 !== 1'b0)        begin errors++; $display("FAIL nomul_we got %b want 0", we0); end
    checks++; if (flags0 !== 4'b0000)  begin errors++; $display("FAIL nomul_flags got %b want 0000", flags0); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL mul_still_running got done=%b want 0", done); end
    lat = 0;
    for (int n = 2; n <= 100; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat !== 33)          begin errors++; $display("FAIL mul15_lat got %0d want 33", lat); end
    checks++; if (result !== 32'd15)   begin errors++; $display("FAIL mul15_result got %0d want 15", result); end
    checks++; if (flags !== 4'b0000)   begin errors++; $display("FAIL mul15_flags got %b want 0000", flags); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid_mul();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
